// File: rtl/usb2_in_sched.sv
// usb2_in_sched: IN-transaction sequencer between the packet TX engine and
// the endpoint buffer mux. Emits a handshake PID or a DATAx packet streamed
// from the selected endpoint buffer, waits for the host ACK, then releases
// the buffer and advances the data toggle.
module usb2_in_sched #(
    parameter logic [15:0] EP_IN_MASK  = 16'h0003,
    parameter logic [9:0]  MAX_PKT     = 10'd512,
    parameter logic [15:0] ACK_TIMEOUT = 16'd800
) (
    input  logic       phy_clk,
    input  logic       reset,
    input  logic       tok_in_valid,
    input  logic [3:0] tok_endp,
    output logic       tok_ready,
    output logic [3:0] sel_endp,
    input  logic [1:0] endp_mode,
    input  logic       buf_out_hasdata,
    input  logic [9:0] buf_out_len,
    output logic [8:0] buf_out_addr,
    input  logic [7:0] buf_out_q,
    output logic       buf_out_arm,
    input  logic       buf_out_arm_ack,
    input  logic [1:0] data_toggle,
    output logic       data_toggle_act,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       tx_last,
    input  logic       hs_ack,
    output logic       err_len,
    output logic       busy
);

    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [1:0] MODE_ISO  = 2'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_HS,
        S_PID,
        S_STREAM,
        S_WAIT_HS,
        S_RELEASE
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [9:0]  len_q;
    logic        is_iso;
    logic [3:0]  hs_pid;
    logic [3:0]  data_pid;
    logic [15:0] timer;

    // read-ahead datapath: one read in flight plus a two-entry byte buffer
    logic        rd_done;
    logic        pending;
    logic [1:0]  fifo_cnt;
    logic [7:0]  fifo_b0;
    logic [7:0]  fifo_b1;
    logic [9:0]  tx_cnt;
    logic        stream_valid;
    logic        pop;
    logic        shift;
    logic        push;
    logic        issue;
    logic [1:0]  cnt_after;
    logic [2:0]  level;

    logic        unused_toggle_msb;
    assign unused_toggle_msb = data_toggle[1];

    assign busy     = (state != S_IDLE);
    assign data_pid = (!is_iso && data_toggle[0]) ? PID_DATA1 : PID_DATA0;

    // state register
    always_ff @(posedge phy_clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // next-state decode and handshake/packet outputs
    always_comb begin
        state_nx        = state;
        tok_ready       = 1'b0;
        tx_valid        = 1'b0;
        tx_data         = '0;
        tx_last         = 1'b0;
        err_len         = 1'b0;
        data_toggle_act = 1'b0;
        buf_out_arm     = 1'b0;
        case (state)
            S_IDLE: begin
                tok_ready = 1'b1;
                if (tok_in_valid) state_nx = S_SETTLE;
            end
            S_SETTLE: state_nx = S_CHECK;
            S_CHECK: begin
                if (!EP_IN_MASK[sel_endp] || !buf_out_hasdata) begin
                    state_nx = S_HS;
                end else if (buf_out_len > MAX_PKT) begin
                    err_len  = 1'b1;
                    state_nx = S_HS;
                end else begin
                    state_nx = S_PID;
                end
            end
            S_HS: begin
                tx_valid = 1'b1;
                tx_data  = {~hs_pid, hs_pid};
                tx_last  = 1'b1;
                if (tx_ready) state_nx = S_IDLE;
            end
            S_PID: begin
                tx_valid = 1'b1;
                tx_data  = {~data_pid, data_pid};
                tx_last  = (len_q == '0);
                if (tx_ready) begin
                    if (len_q != '0) state_nx = S_STREAM;
                    else if (is_iso) state_nx = S_RELEASE;
                    else             state_nx = S_WAIT_HS;
                end
            end
            S_STREAM: begin
                // buffer empty: the byte arriving this cycle is forwarded directly
                tx_valid = stream_valid;
                if (stream_valid) tx_data = (fifo_cnt != 2'd0) ? fifo_b0 : buf_out_q;
                tx_last  = stream_valid && (tx_cnt == len_q - 10'd1);
                if (stream_valid && tx_ready && tx_last)
                    state_nx = is_iso ? S_RELEASE : S_WAIT_HS;
            end
            S_WAIT_HS: begin
                if (hs_ack) begin
                    data_toggle_act = 1'b1;
                    state_nx        = S_RELEASE;
                end else if (timer == ACK_TIMEOUT - 16'd1) begin
                    state_nx = S_IDLE;
                end
            end
            S_RELEASE: begin
                buf_out_arm = 1'b1;
                if (buf_out_arm_ack) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // token latch and per-transaction decision capture
    always_ff @(posedge phy_clk or posedge reset) begin
        if (reset) begin
            sel_endp <= '0;
            len_q    <= '0;
            is_iso   <= 1'b0;
            hs_pid   <= '0;
        end else begin
            if (state == S_IDLE && tok_in_valid) sel_endp <= tok_endp;
            if (state == S_CHECK) begin
                len_q  <= buf_out_len;
                is_iso <= (endp_mode == MODE_ISO);
                hs_pid <= EP_IN_MASK[sel_endp] ? PID_NAK : PID_STALL;
            end
        end
    end

    // read-ahead control: pop, buffer shift/push and read issue
    always_comb begin
        stream_valid = (fifo_cnt != 2'd0) || pending;
        pop          = (state == S_STREAM) && stream_valid && tx_ready;
        shift        = pop && (fifo_cnt != 2'd0);
        cnt_after    = fifo_cnt - {1'b0, shift};
        push         = pending && !(pop && (fifo_cnt == 2'd0));
        level        = {1'b0, fifo_cnt} + {2'b00, pending} - {2'b00, pop};
        issue        = ((state == S_PID && len_q != '0) || state == S_STREAM)
                       && !rd_done && (level < 3'd2);
    end

    // read address, in-flight flag, byte buffer and sent-byte counter
    always_ff @(posedge phy_clk or posedge reset) begin
        if (reset) begin
            buf_out_addr <= '0;
            rd_done      <= 1'b0;
            pending      <= 1'b0;
            fifo_cnt     <= '0;
            fifo_b0      <= '0;
            fifo_b1      <= '0;
            tx_cnt       <= '0;
        end else if (state == S_IDLE) begin
            buf_out_addr <= '0;
            rd_done      <= 1'b0;
            pending      <= 1'b0;
            fifo_cnt     <= '0;
            tx_cnt       <= '0;
        end else begin
            pending <= issue;
            if (issue) begin
                if ({1'b0, buf_out_addr} == len_q - 10'd1) rd_done <= 1'b1;
                else                                       buf_out_addr <= buf_out_addr + 9'd1;
            end
            if (shift) fifo_b0 <= fifo_b1;
            if (push) begin
                if (cnt_after == 2'd0) fifo_b0 <= buf_out_q;
                else                   fifo_b1 <= buf_out_q;
            end
            fifo_cnt <= cnt_after + {1'b0, push};
            if (pop) tx_cnt <= tx_cnt + 10'd1;
        end
    end

    // handshake wait timer, cleared whenever not waiting
    always_ff @(posedge phy_clk or posedge reset) begin
        if (reset)                  timer <= '0;
        else if (state == S_WAIT_HS) timer <= timer + 16'd1;
        else                        timer <= '0;
    end

endmodule

// File: tb/tb_usb2_in_sched.sv
// Self-checking bench for usb2_in_sched: scenario tasks compare the observed
// TX byte stream and strobes against a transaction-level reference model.
module tb_usb2_in_sched;

    localparam logic [15:0] MASK    = 16'h0003;
    localparam int          TIMEOUT = 800;

    logic       phy_clk = 1'b0;
    logic       reset;
    logic       tok_in_valid;
    logic [3:0] tok_endp;
    logic       tok_ready;
    logic [3:0] sel_endp;
    logic [1:0] endp_mode;
    logic       buf_out_hasdata;
    logic [9:0] buf_out_len;
    logic [8:0] buf_out_addr;
    logic [7:0] buf_out_q;
    logic       buf_out_arm;
    logic       buf_out_arm_ack;
    logic [1:0] data_toggle;
    logic       data_toggle_act;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;
    logic       hs_ack;
    logic       err_len;
    logic       busy;

    logic [7:0] mem [0:511];

    usb2_in_sched #(
        .EP_IN_MASK (16'h0003),
        .MAX_PKT    (10'd512),
        .ACK_TIMEOUT(16'd800)
    ) dut (
        .phy_clk        (phy_clk),
        .reset          (reset),
        .tok_in_valid   (tok_in_valid),
        .tok_endp       (tok_endp),
        .tok_ready      (tok_ready),
        .sel_endp       (sel_endp),
        .endp_mode      (endp_mode),
        .buf_out_hasdata(buf_out_hasdata),
        .buf_out_len    (buf_out_len),
        .buf_out_addr   (buf_out_addr),
        .buf_out_q      (buf_out_q),
        .buf_out_arm    (buf_out_arm),
        .buf_out_arm_ack(buf_out_arm_ack),
        .data_toggle    (data_toggle),
        .data_toggle_act(data_toggle_act),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .tx_last        (tx_last),
        .hs_ack         (hs_ack),
        .err_len        (err_len),
        .busy           (busy)
    );

    always #5 phy_clk = ~phy_clk;

    // endpoint buffer: synchronous read, data one cycle after address
    always @(posedge phy_clk) buf_out_q <= mem[buf_out_addr];

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int last_cnt, last_idx, n_toggle, n_err, n_arm_cycles;
    int cyc_first, cyc_last_acc, cyc_idle, max_addr;
    bit arm_seen, exp_tog, exp_arm, exp_err;

    task automatic fill_mem();
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    endtask

    // transaction-level reference: what bytes the host should see and
    // which side effects follow, given endpoint state and whether ACKed
    task automatic model(input int ep, input bit acked);
        int  len;
        bit  iso;
        len = int'(buf_out_len);
        iso = (endp_mode == 2'd1);
        exp_q.delete();
        exp_tog = 0; exp_arm = 0; exp_err = 0;
        if (!MASK[ep]) exp_q.push_back(8'h1E);
        else if (!buf_out_hasdata) exp_q.push_back(8'h5A);
        else if (len > 512) begin
            exp_err = 1;
            exp_q.push_back(8'h5A);
        end else begin
            exp_q.push_back((!iso && data_toggle[0]) ? 8'h4B : 8'hC3);
            for (int i = 0; i < len; i++) exp_q.push_back(mem[i]);
            exp_arm = iso || acked;
            exp_tog = !iso && acked;
        end
    endtask

    // issue one IN token and play host/TX-engine/buffer until back in IDLE.
    // rmode: 0 ready always, 1 alternate, 2 random. ack_delay<0: never ACK.
    task automatic run_in(input int ep, input int rmode, input int ack_delay, input int arm_delay);
        int cyc, ack_at, arm_cnt;
        bit done, prev_stall, prev_last;
        logic [7:0] prev_data;
        got_q.delete();
        last_cnt = 0; last_idx = -1; n_toggle = 0; n_err = 0; n_arm_cycles = 0;
        cyc_first = -1; cyc_last_acc = -1; cyc_idle = -1; max_addr = 0; arm_seen = 0;
        @(negedge phy_clk);
        tok_in_valid = 1; tok_endp = ep[3:0];
        @(negedge phy_clk);
        tok_in_valid = 0;
        #1;
        vectors++;
        if (sel_endp !== ep[3:0] || tok_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL token_latch: sel_endp=%0d tok_ready=%b, want %0d / 0", sel_endp, tok_ready, ep);
        end
        cyc = 0; ack_at = -1; arm_cnt = 0; done = 0; prev_stall = 0; prev_last = 0; prev_data = '0;
        while (!done && cyc < 3000) begin
            case (rmode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = cyc[0];
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            hs_ack = (ack_at >= 0 && cyc == ack_at);
            buf_out_arm_ack = 1'b0;
            if (buf_out_arm) begin
                if (arm_cnt == arm_delay) buf_out_arm_ack = 1'b1;
                arm_cnt++;
            end
            #1;
            if (!busy) begin
                done = 1;
                cyc_idle = cyc;
            end else begin
                if (data_toggle_act) n_toggle++;
                if (err_len) n_err++;
                if (buf_out_arm) begin arm_seen = 1; n_arm_cycles++; end
                if (int'(buf_out_addr) > max_addr) max_addr = int'(buf_out_addr);
                if (prev_stall) begin
                    vectors++;
                    if (tx_valid !== 1'b1 || tx_data !== prev_data || tx_last !== prev_last) begin
                        miscompares++;
                        $display("FAIL stall_hold: valid=%b data=%h last=%b, want 1 %h %b",
                                 tx_valid, tx_data, tx_last, prev_data, prev_last);
                    end
                end
                if (tx_valid && tx_ready) begin
                    got_q.push_back(tx_data);
                    if (cyc_first < 0) cyc_first = cyc;
                    if (tx_last) begin
                        last_cnt++;
                        last_idx = got_q.size() - 1;
                        cyc_last_acc = cyc;
                        if (ack_delay >= 0) ack_at = cyc + ack_delay;
                    end
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
                prev_last  = tx_last;
            end
            @(negedge phy_clk);
            cyc++;
        end
        hs_ack = 0; buf_out_arm_ack = 0;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL txn_timeout: busy still %b after %0d cycles, want 0", busy, cyc);
        end
        if (buf_out_len != 0 && buf_out_len <= 512 && buf_out_hasdata && MASK[ep]) begin
            vectors++;
            if (max_addr > int'(buf_out_len) - 1) begin
                miscompares++;
                $display("FAIL addr_bound: max addr %0d, want <= %0d", max_addr, int'(buf_out_len) - 1);
            end
        end
    endtask

    task automatic set_ep(input logic [1:0] mode, input bit has, input int len, input logic [1:0] tog);
        endp_mode = mode; buf_out_hasdata = has; buf_out_len = 10'(len); data_toggle = tog;
    endtask

    task automatic test_reset();
        reset = 1; tok_in_valid = 0; tok_endp = 0; tx_ready = 0; hs_ack = 0; buf_out_arm_ack = 0;
        set_ep(2'd2, 0, 0, 2'd0);
        fill_mem();
        repeat (3) @(negedge phy_clk);
        vectors++;
        if ({tok_ready, busy, tx_valid, tx_last, buf_out_arm, data_toggle_act, err_len} !== 7'b1000000 ||
            tx_data !== 8'h00 || sel_endp !== 4'h0 || buf_out_addr !== 9'h000) begin
            miscompares++;
            $display("FAIL reset_state: rdy=%b busy=%b v=%b last=%b arm=%b act=%b err=%b data=%h sel=%0d addr=%0d, want 1,0.. zero",
                     tok_ready, busy, tx_valid, tx_last, buf_out_arm, data_toggle_act, err_len, tx_data, sel_endp, buf_out_addr);
        end
        reset = 0;
    endtask

    task automatic test_bulk();
        int bad;
        fill_mem();
        set_ep(2'd2, 1, 4, 2'd0);
        model(1, 1);
        run_in(1, 0, 3, 2);
        bad = (got_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL bulk_bytes: got %0d bytes (%0d bad), want %0d", got_q.size(), bad, exp_q.size()); end
        vectors++;
        if (last_cnt != 1 || last_idx != 4) begin miscompares++; $display("FAIL bulk_last: count %0d at %0d, want 1 at 4", last_cnt, last_idx); end
        vectors++;
        if (cyc_last_acc - cyc_first != 4) begin miscompares++; $display("FAIL bulk_rate: span %0d cycles, want 4", cyc_last_acc - cyc_first); end
        vectors++;
        if (n_toggle != 1 || n_arm_cycles != 3) begin miscompares++; $display("FAIL bulk_release: toggle %0d arm cycles %0d, want 1 / 3", n_toggle, n_arm_cycles); end
        vectors++;
        if (tok_ready !== 1'b1) begin miscompares++; $display("FAIL bulk_idle: tok_ready %b, want 1", tok_ready); end
    endtask

    task automatic test_handshakes();
        set_ep(2'd2, 0, 4, 2'd1);
        run_in(1, 0, 2, 0);
        vectors++;
        if (got_q.size() != 1 || got_q[0] !== 8'h5A || last_cnt != 1 || arm_seen || n_toggle != 0) begin
            miscompares++;
            $display("FAIL nak: %0d bytes first %h last %0d arm %b toggle %0d, want 1 5A 1 0 0",
                     got_q.size(), got_q.size() > 0 ? got_q[0] : 8'h00, last_cnt, arm_seen, n_toggle);
        end
        set_ep(2'd2, 1, 4, 2'd1);
        run_in(3, 0, 2, 0);
        vectors++;
        if (got_q.size() != 1 || got_q[0] !== 8'h1E || last_cnt != 1 || arm_seen || n_toggle != 0) begin
            miscompares++;
            $display("FAIL stall: %0d bytes first %h last %0d arm %b toggle %0d, want 1 1E 1 0 0",
                     got_q.size(), got_q.size() > 0 ? got_q[0] : 8'h00, last_cnt, arm_seen, n_toggle);
        end
    endtask

    task automatic test_zlp();
        set_ep(2'd0, 1, 0, 2'd1);
        run_in(0, 0, 2, 1);
        vectors++;
        if (got_q.size() != 1 || got_q[0] !== 8'h4B || last_cnt != 1 || n_toggle != 1 || !arm_seen) begin
            miscompares++;
            $display("FAIL zlp: %0d bytes first %h last %0d toggle %0d arm %b, want 1 4B 1 1 1",
                     got_q.size(), got_q.size() > 0 ? got_q[0] : 8'h00, last_cnt, n_toggle, arm_seen);
        end
    endtask

    task automatic test_stall_toggle();
        int bad;
        fill_mem();
        set_ep(2'd3, 1, 8, 2'd1);
        model(1, 1);
        run_in(1, 1, 1, 0);
        bad = (got_q.size() != 9) ? 1 : 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        vectors++;
        if (bad != 0 || last_idx != 8) begin miscompares++; $display("FAIL throttle_bytes: got %0d bytes (%0d bad) last at %0d, want 9 0 8", got_q.size(), bad, last_idx); end
    endtask

    task automatic test_timeout_retry();
        int bad;
        fill_mem();
        set_ep(2'd2, 1, 6, 2'd1);
        model(1, 0);
        run_in(1, 0, -1, 0);
        bad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        vectors++;
        if (bad != 0 || got_q.size() != exp_q.size() || arm_seen || n_toggle != 0) begin
            miscompares++;
            $display("FAIL timeout_txn: %0d bytes (%0d bad) arm %b toggle %0d, want %0d 0 0 0", got_q.size(), bad, arm_seen, n_toggle, exp_q.size());
        end
        vectors++;
        if (cyc_idle - cyc_last_acc != TIMEOUT + 1) begin miscompares++; $display("FAIL timeout_len: idle after %0d cycles, want %0d", cyc_idle - cyc_last_acc, TIMEOUT + 1); end
        model(1, 1);
        run_in(1, 0, 2, 0);
        bad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        vectors++;
        if (bad != 0 || got_q.size() != exp_q.size() || !arm_seen || n_toggle != 1) begin
            miscompares++;
            $display("FAIL retry_txn: %0d bytes (%0d bad) arm %b toggle %0d, want %0d 0 1 1", got_q.size(), bad, arm_seen, n_toggle, exp_q.size());
        end
        run_in(1, 0, TIMEOUT, 0);
        vectors++;
        if (!arm_seen || n_toggle != 1) begin miscompares++; $display("FAIL ack_at_expiry: arm %b toggle %0d, want 1 1", arm_seen, n_toggle); end
    endtask

    task automatic test_len_limits();
        int bad;
        fill_mem();
        set_ep(2'd2, 1, 512, 2'd0);
        model(1, 1);
        run_in(1, 0, 1, 0);
        bad = (got_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        vectors++;
        if (bad != 0 || n_err != 0 || max_addr != 511) begin
            miscompares++;
            $display("FAIL len_512: %0d bytes (%0d bad) err %0d max addr %0d, want 513 0 0 511", got_q.size(), bad, n_err, max_addr);
        end
        set_ep(2'd2, 1, 513, 2'd0);
        run_in(1, 0, 1, 0);
        vectors++;
        if (got_q.size() != 1 || got_q[0] !== 8'h5A || n_err != 1 || arm_seen) begin
            miscompares++;
            $display("FAIL len_513: %0d bytes first %h err %0d arm %b, want 1 5A 1 0",
                     got_q.size(), got_q.size() > 0 ? got_q[0] : 8'h00, n_err, arm_seen);
        end
    endtask

    task automatic test_reset_mid();
        int n, bad;
        fill_mem();
        set_ep(2'd2, 1, 10, 2'd1);
        model(1, 1);
        tx_ready = 1;
        @(negedge phy_clk);
        tok_in_valid = 1; tok_endp = 4'd1;
        @(negedge phy_clk);
        tok_in_valid = 0;
        n = 0;
        for (int c = 0; c < 50 && n < 3; c++) begin
            #1;
            if (tx_valid && tx_ready) n++;
            if (n < 3) @(negedge phy_clk);
        end
        #1 reset = 1;
        #1;
        vectors++;
        if ({busy, tx_valid, tx_last, buf_out_arm, data_toggle_act, err_len} !== 6'b0 ||
            tx_data !== 8'h00 || sel_endp !== 4'h0 || buf_out_addr !== 9'h000 || n != 3) begin
            miscompares++;
            $display("FAIL reset_mid: busy=%b v=%b data=%h sel=%0d addr=%0d bytes seen %0d, want all zero, 3",
                     busy, tx_valid, tx_data, sel_endp, buf_out_addr, n);
        end
        @(negedge phy_clk);
        reset = 0;
        run_in(1, 0, 2, 0);
        bad = (got_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        vectors++;
        if (bad != 0 || n_toggle != 1) begin miscompares++; $display("FAIL reset_resend: %0d bytes (%0d bad) toggle %0d, want %0d 0 1", got_q.size(), bad, n_toggle, exp_q.size()); end
    endtask

    task automatic test_random(input int iters);
        int ep, len, bad, sel;
        for (int k = 0; k < iters; k++) begin
            fill_mem();
            ep  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 15)) : int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            len = (sel == 0) ? 0 : (sel == 1) ? 512 : (sel == 2) ? 513 + int'($urandom_range(0, 9)) : int'($urandom_range(1, 40));
            set_ep(2'($urandom_range(0, 3)), ($urandom_range(0, 4) != 0), len, 2'($urandom_range(0, 3)));
            model(ep, 1);
            run_in(ep, 2, int'($urandom_range(1, 10)), int'($urandom_range(0, 4)));
            bad = (got_q.size() != exp_q.size()) ? 1 : 0;
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
            vectors++;
            if (bad != 0 || last_cnt != 1 || last_idx != exp_q.size() - 1) begin
                miscompares++;
                $display("FAIL rand_bytes[%0d]: ep %0d len %0d: %0d bytes (%0d bad) last %0d@%0d, want %0d bytes",
                         k, ep, len, got_q.size(), bad, last_cnt, last_idx, exp_q.size());
            end
            vectors++;
            if (n_toggle != int'(exp_tog) || arm_seen != exp_arm || n_err != int'(exp_err)) begin
                miscompares++;
                $display("FAIL rand_effects[%0d]: toggle %0d arm %b err %0d, want %0d %b %0d",
                         k, n_toggle, arm_seen, n_err, exp_tog, exp_arm, exp_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bulk();
        test_handshakes();
        test_zlp();
        test_stall_toggle();
        test_timeout_retry();
        test_len_limits();
        test_reset_mid();
        test_random(12);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation exceeded time limit, want completion");
        $fatal(1, "watchdog");
    end

endmodule
